// File: rtl/rvx_spi_defines.sv
`default_nettype none
// ============================================================================
//  Module      : rvx_spi_defines
//  Description : Constants shared by the rvx SPI manager and subordinate:
//                mode encoding built from {cpol, cpha} and FSM state codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package rvx_spi_defines;

  // SPI mode number is {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Subordinate FSM state encodings
  localparam logic [1:0] SPI_ST_IDLE          = 2'd0;
  localparam logic [1:0] SPI_ST_ACTIVE        = 2'd1;
  localparam logic [1:0] SPI_ST_WAIT_DESELECT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE          = SPI_ST_IDLE,
    ST_ACTIVE        = SPI_ST_ACTIVE,
    ST_WAIT_DESELECT = SPI_ST_WAIT_DESELECT
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/rvx_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : rvx_synchronizer
//  Description : Two-flop synchronizer for asynchronous inputs, any width.
//                Both stages clear to zero on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvx_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two register stages to settle metastability
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/rvx_spi_subordinate.sv
`default_nettype none
// ============================================================================
//  Module      : rvx_spi_subordinate
//  Description : Oversampled SPI subordinate endpoint. Deserializes pico into
//                words, serializes a holding register onto poci and offers a
//                word-level TX/RX handshake in the system clock domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvx_spi_subordinate
  import rvx_spi_defines::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  pico,
  input  logic                  cs,
  output logic                  poci,
  output logic                  poci_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_abort,
  output logic                  busy
);

  localparam int                 c_CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [2:0]            w_sync;        // {sclk, pico, cs} after 2 flops
  logic [2:0]            r_sync_d;      // edge-detect stage, aligned with events
  logic                  r_sclk_edge;
  logic                  r_cs_fall;
  logic                  r_cs_rise;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  w_cpha;
  logic                  w_lead;
  logic                  w_trail;
  spi_state_t            r_state;
  spi_state_t            w_state_next;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_sample;
  logic                  w_start;
  logic                  w_stop;
  logic                  w_launch;
  logic                  r_active;
  logic [c_CNT_W-1:0]    r_bit_cnt;
  logic [DATA_WIDTH-2:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] w_rx_next;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic                  r_under_pend;

  rvx_synchronizer #(.WIDTH(3)) u_sync (
    .clock (clock),
    .reset (reset),
    .i_d   ({sclk, pico, cs}),
    .o_q   (w_sync)
  );

  // Third stage: registered edge events; r_sync_d holds the post-edge levels
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync_d    <= '0;
      r_sclk_edge <= 1'b0;
      r_cs_fall   <= 1'b0;
      r_cs_rise   <= 1'b0;
    end else begin
      r_sync_d    <= w_sync;
      r_sclk_edge <= w_sync[2] ^ r_sync_d[2];
      r_cs_fall   <= r_sync_d[0] & ~w_sync[0];
      r_cs_rise   <= ~r_sync_d[0] & w_sync[0];
    end
  end

  // Mode tracks the pins while deselected and freezes once cs is seen low
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
    end else if (r_sync_d[0]) begin
      r_cpol <= cpol;
      r_cpha <= cpha;
    end
  end

  // Decode the latched mode into the phase selection
  always_comb begin
    w_cpha = 1'b0;
    case ({r_cpol, r_cpha})
      SPI_MODE0, SPI_MODE2: w_cpha = 1'b0;
      SPI_MODE1, SPI_MODE3: w_cpha = 1'b1;
      default:              w_cpha = 1'b0;
    endcase
  end

  assign w_lead    = r_sclk_edge & (r_sync_d[2] != r_cpol);
  assign w_trail   = r_sclk_edge & (r_sync_d[2] == r_cpol);
  assign w_rx_next = {r_rx_shift, r_sync_d[1]};

  // FSM state register; comes out of reset waiting for a clean deselect
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_WAIT_DESELECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and per-cycle datapath strobes
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_sample     = 1'b0;
    w_start      = 1'b0;
    w_stop       = 1'b0;
    w_launch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_cs_fall) begin
          w_state_next = ST_ACTIVE;
          w_start      = 1'b1;
          w_load       = ~w_cpha;
        end
      end
      ST_ACTIVE: begin
        if (r_cs_rise) begin
          w_state_next = ST_IDLE;
          w_stop       = 1'b1;
        end else if (w_cpha) begin
          // Bit 0 leading edge loads, other leading edges shift
          w_load   = w_lead & (r_bit_cnt == '0);
          w_shift  = w_lead & (r_bit_cnt != '0);
          w_sample = w_trail;
        end else begin
          // Trailing edge after a completed word loads the next one
          w_sample = w_lead;
          w_launch = w_lead;
          w_load   = w_trail & (r_bit_cnt == '0);
          w_shift  = w_trail & (r_bit_cnt != '0);
        end
      end
      ST_WAIT_DESELECT: begin
        if (r_cs_rise) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_WAIT_DESELECT;
    endcase
  end

  // Receive path: bit counter, deserializer and abort detection
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_active   <= 1'b0;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_abort   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_abort <= 1'b0;
      r_active <= (w_state_next == ST_ACTIVE);
      if (w_start) begin
        r_bit_cnt <= '0;
      end
      if (w_sample) begin
        if (r_bit_cnt == c_CNT_LAST) begin
          rx_data   <= w_rx_next;
          rx_valid  <= 1'b1;
          r_bit_cnt <= '0;
        end else begin
          r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
          r_bit_cnt  <= r_bit_cnt + c_CNT_ONE;
        end
      end
      if (w_stop) begin
        rx_abort  <= (r_bit_cnt != '0);
        r_bit_cnt <= '0;
      end
    end
  end

  // Transmit path: holding register, shift register and underrun reporting.
  // In cpha=0 a load can happen on the frame's final trailing edge, so an
  // empty load is only reported once that word actually starts going out.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tx_shift   <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_under_pend <= 1'b0;
      tx_underrun  <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (w_launch && r_under_pend) begin
        tx_underrun  <= 1'b1;
        r_under_pend <= 1'b0;
      end
      if (w_load) begin
        if (r_hold_full) begin
          r_tx_shift  <= r_hold;
          r_hold_full <= 1'b0;
        end else if (tx_valid) begin
          r_tx_shift <= tx_data;
        end else begin
          r_tx_shift <= '0;
          if (w_cpha) begin
            tx_underrun <= 1'b1;
          end else begin
            r_under_pend <= 1'b1;
          end
        end
      end else begin
        if (w_shift) begin
          r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
        if (w_stop) begin
          r_tx_shift   <= '0;
          r_under_pend <= 1'b0;
        end
        if (tx_valid && !r_hold_full) begin
          r_hold      <= tx_data;
          r_hold_full <= 1'b1;
        end
      end
    end
  end

  assign poci     = r_tx_shift[DATA_WIDTH-1];
  assign poci_oe  = r_active;
  assign busy     = r_active;
  assign tx_ready = ~r_hold_full;

endmodule
`default_nettype wire

// File: doc/rvx_spi_subordinate.md
# rvx_spi_subordinate

SPI subordinate (peripheral-side) endpoint, the far end of the rvx SPI manager port (`sclk`, `pico`, `poci`, `cs`). It oversamples the SPI pins in the system clock domain, deserializes `pico` into words, serializes words onto `poci`, and presents a word-level handshake to local logic. It is used on boards or test harnesses where an rvx instance, or another manager, talks to this design over SPI.

## Interface
- `DATA_WIDTH`, default 8: bits per SPI word, sent and received MSB first.
- `clock` input, 1: system clock; must be at least 8× the `sclk` frequency.
- `reset` input, 1: synchronous, active-low reset.
- `cpol` input, 1: SPI clock idle level; sampled only while `cs` is deasserted.
- `cpha` input, 1: SPI clock phase; sampled only while `cs` is deasserted.
- `sclk` input, 1: SPI clock from the manager; asynchronous to `clock`.
- `pico` input, 1: manager-to-subordinate data; asynchronous.
- `cs` input, 1: chip select, active-low; asynchronous.
- `poci` output, 1: subordinate-to-manager data.
- `poci_oe` output, 1: output enable for `poci`; high only while selected.
- `tx_data` input, DATA_WIDTH: next word to transmit.
- `tx_valid` input, 1: `tx_data` is valid.
- `tx_ready` output, 1: the TX holding register is empty.
- `tx_underrun` output, 1: one-cycle pulse when a word is launched with the holding register empty.
- `rx_data` output, DATA_WIDTH: last complete received word; holds until the next word completes.
- `rx_valid` output, 1: one-cycle pulse when `rx_data` updates.
- `rx_abort` output, 1: one-cycle pulse when `cs` deasserts with 1 to DATA_WIDTH-1 bits received.
- `busy` output, 1: a frame is active (synchronized `cs` low).

## Operation
- **Synchronization**
  - `sclk`, `pico` and `cs` each pass through a 2-FF synchronizer.
  - A third register stage provides edge detection.
- **Edge definitions**
  - Leading edge = the first `sclk` transition away from the idle level `cpol`; trailing edge = the return transition.
  - Mode (`cpol`, `cpha`) is latched on the synchronized `cs` falling edge and held for the whole frame.
- **FSM states**
  - IDLE: `cs` high; `poci_oe`=0; bit counter = 0.
  - ACTIVE: `cs` low; `poci_oe`=1.
  - WAIT_DESELECT: entered after reset if `cs` is already low. The frame in progress is ignored (`poci_oe`=0, no rx/tx activity) until `cs` is seen high, then the FSM goes to IDLE.
- **IDLE → ACTIVE** on the `cs` falling edge.
- **cpha=0**
  - A word is loaded into the TX shift register on the `cs` falling edge and on the trailing edge that follows each W-th sample.
  - `pico` is sampled on leading edges; `poci` shifts on trailing edges.
- **cpha=1**
  - A word is loaded on the leading edge of bit 0.
  - `poci` shifts on all other leading edges; `pico` is sampled on trailing edges.
- **Word load**
  - The shift register takes the holding register contents, and `tx_ready` rises.
  - If the holding register is empty: the shift register is loaded with all zeros and `tx_underrun` pulses.
  - If `tx_valid`&`tx_ready` occurs in the same cycle as a load: that word bypasses into the shift register and no underrun is flagged.
- **Bit counter** counts samples 0..DATA_WIDTH-1.
  - On the DATA_WIDTH-th sample: `rx_data` takes the completed word, `rx_valid` pulses, and the counter wraps to 0. Frames of any multiple of DATA_WIDTH are supported.
- **`cs` rising mid-word**
  - The partial RX word is discarded and `rx_abort` pulses if the counter is ≠ 0.
  - The TX shift register content is dropped; the holding register is kept.
  - The FSM returns to IDLE.
- **`cs` rising at a word boundary:** no pulse.
- **`rx_valid` has no backpressure:** an unread word is overwritten.

## Timing
- **Reset values:** `poci`=0, `poci_oe`=0, `tx_ready`=1, `tx_underrun`=0, `rx_data`=0, `rx_valid`=0, `rx_abort`=0, `busy`=0; holding register empty.
- **Pin-to-internal-event latency:** 3 `clock` cycles from a pin edge to the internal edge event.
- **`poci` update:** `poci` and `poci_oe` are registered and change 4 `clock` cycles after the triggering `sclk`/`cs` edge.
- **`rx_valid`:** asserted 4 cycles after the final sampling `sclk` edge.
- **Manager timing requirements:**
  - `sclk` half period ≥ 4 `clock` cycles.
  - `cs`-fall to first `sclk` edge ≥ 4 `clock` cycles.
  - `cs` high time ≥ 4 `clock` cycles.
- **TX handshake:** a transfer occurs on a `clock` edge with `tx_valid`=`tx_ready`=1. `tx_ready` falls the following cycle.

## Structure
- **Shared constants in `rvx_spi_defines`:** mode encoding (`SPI_MODE0`..`SPI_MODE3`, from `cpol`/`cpha`) and the FSM state encodings; the rvx SPI manager uses the same header.
- **Sub-module:** `rvx_synchronizer` (2-FF, parameterized width), instantiated once with width 3 for `sclk`, `pico` and `cs`.
- **Everything else lives in `rvx_spi_subordinate`:** FSM, bit counter, shift registers and holding register.

## Test plan
- **Mode 0 (cpol=0, cpha=0), `clock` = 10× `sclk`:** pre-load `tx_data`=0xA5; manager sends 0x3C → manager receives 0xA5; `rx_data`=0x3C with a single `rx_valid` pulse; `tx_underrun`=0.
- **Modes 1, 2 and 3:** same exchange with `tx_data`=0x81, `pico` word 0x7E → `poci` bits appear on the mode-correct edge; `rx_data`=0x7E in every mode.
- **Back-to-back 3-word frame with only 0x11 pre-loaded:** 0x22 is written during word 0 → manager reads 0x11, 0x22, 0x00; `tx_underrun` pulses once at the third load.
- **`cs` raised after 5 bits of 0xF0:** `rx_abort` pulses; no `rx_valid`; the next full frame sending 0x0F → `rx_data`=0x0F.
- **Reset asserted mid-word with `cs` held low:** outputs return to reset values and stay idle for the rest of that frame; after `cs` rises, a new frame sending 0x5A → `rx_data`=0x5A.
- **`tx_valid` asserted in the same cycle as the load event (holding register empty), `tx_data`=0xC3:** manager receives 0xC3; no `tx_underrun`.
